uart_rx: RTL and testbench
==========================

# uart_rx

Serial UART receiver, the counterpart of the team's `uart_tx`. It oversamples an asynchronous 8N1 line (idle-high, one start bit, 8 data bits LSB first, one stop bit) and recovers each byte. Received bytes are presented with a one-cycle `valid` strobe, and malformed frames are flagged with `frame_err`. It sits between the board RX pin and the user logic that consumes bytes.

## Interface
Parameters:
- `OVERSAMPLE`, 16, number of `clk_baud` cycles per bit period. Must be even and at least 4.

Ports:
- `clk_baud`  in  1  oversampling clock, running at `OVERSAMPLE` × baud rate.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `en`  in  1  receiver enable. Sampled only in IDLE.
- `rx`  in  1  asynchronous serial line, idle high.
- `data`  out  8  last received byte. Holds its value until the next frame completes.
- `valid`  out  1  one-cycle pulse: `data` was updated by a good frame.
- `frame_err`  out  1  one-cycle pulse: the stop bit sampled 0.
- `busy`  out  1  high while a frame is being received (START/DATA/STOP).

## Operation
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer whose flops reset to 1; its output is `rx_s`. All decisions use `rx_s`.
- **Counters.**
  - Tick counter `cnt` spans 0..`OVERSAMPLE`-1.
  - Bit index spans 0..7.
  - 8-bit shift register shifts right, with the new bit entering at the MSB.
- **State machine** (IDLE, START, DATA, STOP):
  - **IDLE:** If `en`=1, `armed`=1 and `rx_s`=0, go to START with `cnt`=0. If `rx_s`=1, set `armed`=1.
  - **START:** `cnt` increments. At `cnt`==`OVERSAMPLE`/2-1:
    - `rx_s`=0: go to DATA with `cnt`=0 and bit index 0.
    - `rx_s`=1: this is a false start; return to IDLE with no outputs pulsed.
  - **DATA:** At `cnt`==`OVERSAMPLE`-1, shift in `rx_s`, clear `cnt` and increment the bit index. After bit 7 is sampled, go to STOP.
  - **STOP:** At `cnt`==`OVERSAMPLE`-1, load the shift register into `data` and return to IDLE.
    - `rx_s`=1: pulse `valid`.
    - `rx_s`=0: pulse `frame_err` and clear `armed`.
- **Break handling.** After a framing error, `armed`=0, so a line held low does not start a new frame until `rx_s` has been seen high.
- **Enable.** `en` is checked only in IDLE. Dropping `en` mid-frame does not abort the frame in progress.
- **Outputs.** `valid`, `frame_err`, `busy` and `data` are registered. `valid` and `frame_err` are never high in the same cycle.
- **Resynchronization.** Returning to IDLE at mid-stop-bit lets the receiver resynchronize on a start bit that immediately follows the stop bit, giving back-to-back frames with no idle gap.

## Timing
- **Reset values:** `data`=8'h00, `valid`=0, `frame_err`=0, `busy`=0, state=IDLE, `armed`=1, synchronizer flops=1, counters=0.
- **Reset mid-frame:** asserting `rst` aborts the frame immediately and forces all outputs to their reset values without waiting for a clock. Reception resumes on the first start bit after release.
- **Sample points:** each data bit is sampled `OVERSAMPLE` cycles after the previous sample point. The first data sample is 1.5 bit periods after start detection.
- **Latency:** `valid`/`frame_err` rise between 9.5·`OVERSAMPLE`+1 and 9.5·`OVERSAMPLE`+4 cycles after the falling edge of `rx`. For `OVERSAMPLE`=16 this is cycles 153..156.
- **Busy window:** `busy` rises within 3 cycles of the start edge and falls in the same cycle that `valid`/`frame_err` rise.
- **Glitch rejection:** a low glitch shorter than `OVERSAMPLE`/2-2 cycles never reaches DATA.
- **Minimum frame spacing:** 9.5 bit periods start-to-start. Frames sent at exactly 10 bit periods with no gap must all be received.

## Test plan
All tests use `OVERSAMPLE`=16 and drive `rx` at 16 `clk_baud` cycles per bit.
- **Single byte:** after reset release with `en`=1, send 0x4E → one `valid` pulse within cycles 153..156, `data`=0x4E, `frame_err` never high.
- **Back-to-back frames:** send 0x55, 0x00 and 0xFF with no idle gap → three `valid` pulses, 160 cycles apart, with `data` = 0x55, 0x00, 0xFF in order.
- **Glitch rejection:** drive `rx` low for 4 cycles, then high → `busy` pulses for at most 8 cycles, no `valid`/`frame_err`, and `data` unchanged.
- **Framing error and break:** send 0xA5 with stop bit 0, then hold `rx` low for 40 bit periods, then release and send 0x3C:
  - first frame → `frame_err` pulse with `data`=0xA5 and no `valid`;
  - hold period → no further pulses;
  - after release → 0x3C received with `valid`.
- **Reset mid-frame:** pull `rst` low during bit 4 of 0x81 → outputs return to reset values without a clock edge and no pulse is produced. After release, 0x81 is received correctly.
- **Enable gating:** with `en`=0 send 0x12 → no `busy`, no pulses. Then set `en`=1 and send 0x34 → `valid` with `data`=0x34.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples an idle-high serial line, recovers bytes and
// flags frames whose stop bit reads low.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_baud,
  input  logic       rst,
  input  logic       en,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_param
    $error("uart_rx: OVERSAMPLE must be even and at least 4");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_r;
  logic          rx_meta_r;
  logic          rx_sync_r;
  logic          rx_s;
  logic [CW-1:0] cnt_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          armed_r;
  logic [7:0]    data_r;
  logic          valid_r;
  logic          frame_err_r;
  logic          busy_r;

  assign rx_s      = rx_sync_r;
  assign data      = data_r;
  assign valid     = valid_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

  // Two-flop synchronizer for the asynchronous line, idling high.
  always_ff @(posedge clk_baud or negedge rst) begin
    if (!rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Frame FSM with counters, shift register and registered outputs.
  always_ff @(posedge clk_baud or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      armed_r     <= 1'b1;
      data_r      <= 8'h00;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // A line held low after a bad stop bit must go high before re-arming.
          if (rx_s) begin
            armed_r <= 1'b1;
          end
          if (en && armed_r && !rx_s) begin
            state_r <= START;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
          end
        end
        START: begin
          if (cnt_r == CNT_HALF) begin
            if (!rx_s) begin
              state_r   <= DATA;
              cnt_r     <= '0;
              bit_idx_r <= 3'd0;
            end else begin
              state_r <= IDLE;
              cnt_r   <= '0;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DATA: begin
          if (cnt_r == CNT_LAST) begin
            shift_r   <= {rx_s, shift_r[7:1]};
            cnt_r     <= '0;
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit leaves room to catch an abutting start bit.
          if (cnt_r == CNT_LAST) begin
            data_r  <= shift_r;
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            if (rx_s) begin
              valid_r <= 1'b1;
            end else begin
              frame_err_r <= 1'b1;
              armed_r     <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: expected bytes are queued as frames are sent and
// matched against valid/frame_err pulses, including pulse latency.
module tb_uart_rx;

  logic       clk_baud;
  logic       rst;
  logic       en;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  typedef struct {
    int         kind;   // 1 = valid, 2 = frame_err
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc;
  int   checks;
  int   errors;
  int   busy_cycles;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk_baud  (clk_baud),
    .rst       (rst),
    .en        (en),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk_baud = 1'b0;
  always #5 clk_baud = ~clk_baud;

  always @(posedge clk_baud) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_baud);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int kind);
    exp_t e;
    if (kind != 0) begin
      e.kind  = kind;
      e.data  = b;
      e.start = cyc;
      sb.push_back(e);
    end
    rx = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) tick();
    end
    rx = stop_bit;
    repeat (16) tick();
  endtask

  // Scoreboard: every pulse must match the oldest expected frame.
  always @(negedge clk_baud) begin
    if (busy) busy_cycles++;
    if (valid || frame_err) begin
      chk("pulse_exclusive", {31'd0, valid & frame_err}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, valid, frame_err}, 32'd0);
      end else begin
        cur = sb.pop_front();
        chk("pulse_kind", valid ? 32'd1 : 32'd2, cur.kind);
        chk("pulse_data", {24'd0, data}, {24'd0, cur.data});
        chk("latency_153_156",
            {31'd0, ((cyc - cur.start) >= 153) && ((cyc - cur.start) <= 156)}, 32'd1);
      end
    end
  end

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    busy_cycles = 0;
    rst = 1'b0;
    en = 1'b1;
    rx = 1'b1;
    repeat (3) tick();
    chk("reset_data", {24'd0, data}, 32'h00);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    idle(5);

    // Single byte
    send_frame(8'h4E, 1'b1, 1);
    idle(20);
    chk("single_data", {24'd0, data}, 32'h4E);
    chk("single_drained", sb.size(), 32'd0);

    // Back-to-back frames with no idle gap
    send_frame(8'h55, 1'b1, 1);
    send_frame(8'h00, 1'b1, 1);
    send_frame(8'hFF, 1'b1, 1);
    idle(20);
    chk("b2b_drained", sb.size(), 32'd0);

    // Short low glitch
    busy_cycles = 0;
    rx = 1'b0;
    repeat (4) tick();
    idle(30);
    chk("glitch_busy_le8", {31'd0, busy_cycles <= 8}, 32'd1);
    chk("glitch_busy_seen", {31'd0, busy_cycles > 0}, 32'd1);
    chk("glitch_data_kept", {24'd0, data}, 32'hFF);

    // Framing error, then break held low, then a good frame
    send_frame(8'hA5, 1'b0, 2);
    rx = 1'b0;
    busy_cycles = 0;
    repeat (624) tick();
    chk("break_drained", sb.size(), 32'd0);
    chk("break_no_busy", busy_cycles, 32'd0);
    chk("break_data", {24'd0, data}, 32'hA5);
    idle(32);
    send_frame(8'h3C, 1'b1, 1);
    idle(20);
    chk("after_break_data", {24'd0, data}, 32'h3C);

    // Reset during bit 4 of 0x81
    rx = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0) ? 1'b1 : 1'b0;
      repeat (16) tick();
    end
    rx = 1'b0;
    repeat (8) tick();
    chk("midframe_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_data", {24'd0, data}, 32'h00);
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_valid", {31'd0, valid}, 32'd0);
    chk("rst_async_frame_err", {31'd0, frame_err}, 32'd0);
    rx = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    idle(20);
    send_frame(8'h81, 1'b1, 1);
    idle(20);
    chk("after_rst_data", {24'd0, data}, 32'h81);

    // Enable gating
    en = 1'b0;
    busy_cycles = 0;
    send_frame(8'h12, 1'b1, 0);
    idle(20);
    chk("disabled_no_busy", busy_cycles, 32'd0);
    chk("disabled_data_kept", {24'd0, data}, 32'h81);
    en = 1'b1;
    idle(4);
    send_frame(8'h34, 1'b1, 1);
    idle(20);
    chk("enabled_data", {24'd0, data}, 32'h34);
    chk("final_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
